team_01_gpio_pattern_gen: RTL

Stimulus source inside the team_01 user project. It drives deterministic, self-timed patterns onto the 34 checked GPIO bits, which map to {mprj_io[37:5], mprj_io[0]}. The caravel-level bench samples and compares those bits. Started by a one-cycle pulse from the LA/Wishbone control logic; reports busy/done back to it.

---
 rtl/team_01_pkg.sv | 36 +++
 rtl/team_01_lfsr34.sv | 35 +++
 rtl/team_01_gpio_pattern_gen.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/team_01_pkg.sv
// Shared types and constants for the team_01 GPIO pattern generator.
package team_01_pkg;

    localparam int LFSR_W = 34;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_CNT  = 2'd0,
        MODE_WALK = 2'd1,
        MODE_LFSR = 2'd2,
        MODE_CHK  = 2'd3
    } mode_e;

    localparam logic [LFSR_W-1:0] CHK_EVEN = 34'h2_AAAA_AAAA;
    localparam logic [LFSR_W-1:0] CHK_ODD  = 34'h1_5555_5555;

    localparam int TAP_A = 33;
    localparam int TAP_B = 26;
    localparam int TAP_C = 1;
    localparam int TAP_D = 0;

    // x^34 + x^27 + x^2 + x + 1, Fibonacci form
    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s
    );
        return {s[LFSR_W-2:0],
                s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
    endfunction

endpackage

// File: rtl/team_01_lfsr34.sv
// 34-bit Fibonacci LFSR with synchronous load and step enable.
module team_01_lfsr34
    import team_01_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (advance) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/team_01_gpio_pattern_gen.sv
// Self-timed GPIO stimulus source: FSM, prescaler and pattern mux.
module team_01_gpio_pattern_gen
    import team_01_pkg::*;
#(
    parameter int                WIDTH     = 34,
    parameter int                PRESCALE  = 4,
    parameter int                NUM_STEPS = 16,
    parameter logic [WIDTH-1:0]  LFSR_SEED = 34'h1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             en,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oeb,
    output logic             busy,
    output logic             done,
    output logic [15:0]      step_cnt
);

    localparam int PW = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [15:0]   S_LAST = 16'(NUM_STEPS - 1);
    localparam logic [WIDTH-1:0] SEED =
        (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [PW-1:0]     cnt_q, cnt_d;
    logic [15:0]       step_q, step_d;
    logic [WIDTH-1:0]  gpio_q, gpio_d;
    logic [WIDTH-1:0]  oeb_q, oeb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              lfsr_load;
    logic              lfsr_adv;
    logic [WIDTH-1:0]  lfsr_q;

    team_01_lfsr34 u_lfsr (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .load    (lfsr_load),
        .seed    (SEED),
        .advance (lfsr_adv),
        .q       (lfsr_q)
    );

    // l is the LFSR value belonging to step n
    function automatic logic [WIDTH-1:0] pat(
        input mode_e            m,
        input logic [15:0]      n,
        input logic [WIDTH-1:0] l
    );
        logic [WIDTH-1:0] r;
        unique case (m)
            MODE_CNT:  r = WIDTH'(n);
            MODE_WALK: r = WIDTH'(1) << (int'(n) % WIDTH);
            MODE_LFSR: r = l;
            MODE_CHK:  r = n[0] ? WIDTH'(CHK_ODD) : WIDTH'(CHK_EVEN);
            default:   r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        gpio_d    = gpio_q;
        oeb_d     = oeb_q;
        busy_d    = busy_q;
        done_d    = done_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        if (!en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            step_d    = '0;
            gpio_d    = '0;
            oeb_d     = '1;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            lfsr_load = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) state_d = LOAD;
                end
                LOAD: begin
                    state_d   = RUN;
                    mode_d    = mode_e'(mode);
                    lfsr_load = 1'b1;
                    cnt_d     = '0;
                    step_d    = '0;
                    gpio_d    = pat(mode_e'(mode), 16'd0, SEED);
                    oeb_d     = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                end
                RUN: begin
                    if (cnt_q == P_LAST) begin
                        cnt_d = '0;
                        if (step_q == S_LAST) begin
                            state_d = DONE;
                            gpio_d  = '1;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            step_d   = step_q + 16'd1;
                            lfsr_adv = 1'b1;
                            gpio_d   = pat(mode_q, step_q + 16'd1,
                                           WIDTH'(lfsr_next(lfsr_q)));
                        end
                    end else begin
                        cnt_d = cnt_q + PW'(1);
                    end
                end
                DONE: begin
                    if (start) begin
                        state_d = LOAD;
                        done_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            mode_q  <= MODE_CNT;
            cnt_q   <= '0;
            step_q  <= '0;
            gpio_q  <= '0;
            oeb_q   <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            gpio_q  <= gpio_d;
            oeb_q   <= oeb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign gpio_out = gpio_q;
    assign gpio_oeb = oeb_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_cnt = step_q;

endmodule
